// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter.
// State, mode and op encodings plus an index-width helper.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    ARB_RR,
    ARB_FIXED
  } arb_mode_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Searches from ptr upward, wrapping; ptr tied to 0 gives fixed priority.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// N-port arbiter in front of the single SDRAM controller interface.
// One transaction in flight; response routed back to the owning port.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_LEN       = DATA_WIDTH / 8,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             p_rd,
  input  logic [NUM_PORTS*WORD_LEN-1:0]    p_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
  output logic [NUM_PORTS-1:0]             p_rdy,
  output logic [NUM_PORTS-1:0]             p_rvalid,
  output logic [NUM_PORTS-1:0]             p_wvalid,
  output logic [NUM_PORTS-1:0]             p_error,
  output logic [DATA_WIDTH-1:0]            p_rdata,
  output logic                             m_rd,
  output logic [WORD_LEN-1:0]              m_wr,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_rdy,
  input  logic                             m_rvalid,
  input  logic                             m_wvalid,
  input  logic                             m_error,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             busy
);

  localparam int IW = idx_w(NUM_PORTS);
  localparam int TW = idx_w(TIMEOUT_CYCLES + 1);
  localparam bit WD_EN = TIMEOUT_CYCLES > 0;
  localparam bit FIXED = ARB_MODE == int'(ARB_FIXED);
  localparam logic [TW-1:0] T_LAST =
    TW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t state, state_nxt;

  logic [NUM_PORTS-1:0]  req, wreq, gnt;
  logic [IW-1:0]         gidx, rr_ptr, arb_ptr;
  logic [IW-1:0]         owner, own_nxt;
  logic                  any_req;
  op_t                   op, op_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [WORD_LEN-1:0]   strb_q;
  logic [TW-1:0]         timer;
  logic                  m_act;
  logic                  rv_q, wv_q, er_q;
  logic                  accept, timeout, done;
  logic                  rd_ok, wr_ok;

  always_comb begin
    req  = '0;
    wreq = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wreq[i] = |p_wr[i*WORD_LEN +: WORD_LEN];
      req[i]  = p_rd[i] | wreq[i];
    end
  end

  assign arb_ptr = FIXED ? '0 : rr_ptr;

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .req (req),
    .ptr (arb_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any_req)
  );

  // Write wins when a port raises both read and strobes.
  assign op_nxt  = |(gnt & wreq) ? OP_WR : OP_RD;
  assign own_nxt = (owner == IW'(NUM_PORTS - 1)) ?
                   '0 : owner + 1'b1;

  assign accept  = (state == ISSUE) && m_act && m_rdy;
  assign timeout = WD_EN && (timer == T_LAST);
  assign done    = m_rvalid | m_wvalid | m_error;
  assign rd_ok   = (op == OP_RD) && m_rvalid &&
                   !m_wvalid && !m_error;
  assign wr_ok   = (op == OP_WR) && m_wvalid &&
                   !m_rvalid && !m_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        if (timeout)     state_nxt = IDLE;
        else if (accept) state_nxt = WAIT;
      end
      WAIT:  if (done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= '0;
      rr_ptr  <= '0;
      op      <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      timer   <= '0;
      m_act   <= 1'b0;
      rv_q    <= 1'b0;
      wv_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      wv_q <= 1'b0;
      er_q <= 1'b0;
      unique case (state)
        IDLE: if (any_req) begin
          owner   <= gidx;
          op      <= op_nxt;
          addr_q  <= p_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q <= p_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
          strb_q  <= p_wr[int'(gidx)*WORD_LEN +: WORD_LEN];
          timer   <= '0;
        end
        ISSUE: begin
          timer <= timer + 1'b1;
          m_act <= !(accept || timeout);
          if (timeout) begin
            er_q   <= 1'b1;
            rr_ptr <= own_nxt;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (done) begin
            // Mismatched or multiple completions count as errors.
            rv_q    <= rd_ok;
            wv_q    <= wr_ok;
            er_q    <= !(rd_ok || wr_ok);
            rdata_q <= m_rdata;
            rr_ptr  <= own_nxt;
          end else if (timeout) begin
            er_q   <= 1'b1;
            rr_ptr <= own_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    p_rdy    = NUM_PORTS'(accept) << owner;
    p_rvalid = NUM_PORTS'(rv_q) << owner;
    p_wvalid = NUM_PORTS'(wv_q) << owner;
    p_error  = NUM_PORTS'(er_q) << owner;
    m_rd     = m_act && (op == OP_RD);
    m_wr     = (m_act && (op == OP_WR)) ? strb_q : '0;
    busy     = state != IDLE;
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign p_rdata = rdata_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: RR instance plus a
// fixed-priority instance driven by an auto-responding controller.
module tb_sdram_port_arb;
  import sdram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    p_rd;
  logic [N*WL-1:0] p_wr;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wdata;

  logic [N-1:0]  p_rdy, p_rvalid, p_wvalid, p_error;
  logic [DW-1:0] p_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic          m_rd, busy;
  logic [WL-1:0] m_wr;
  logic          m_rdy, m_rvalid, m_wvalid, m_error;

  logic [N-1:0]  f_p_rdy, f_p_rvalid, f_p_wvalid, f_p_error;
  logic [DW-1:0] f_p_rdata, f_m_wdata;
  logic [AW-1:0] f_m_addr;
  logic          f_m_rd, f_busy;
  logic [WL-1:0] f_m_wr;
  logic          f_m_rdy;
  logic          f_m_rvalid = 1'b0;
  logic          f_m_wvalid = 1'b0;

  int checks = 0;
  int passed = 0;
  bit fx_on  = 1'b0;
  int fx_cnt = 0;
  int fx_bad = 0;

  sdram_port_arb #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .WORD_LEN(WL), .ARB_MODE(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p_rd(p_rd), .p_wr(p_wr),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdy(p_rdy), .p_rvalid(p_rvalid),
    .p_wvalid(p_wvalid), .p_error(p_error),
    .p_rdata(p_rdata),
    .m_rd(m_rd), .m_wr(m_wr),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdy(m_rdy), .m_rvalid(m_rvalid),
    .m_wvalid(m_wvalid), .m_error(m_error),
    .m_rdata(m_rdata), .busy(busy)
  );

  sdram_port_arb #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .WORD_LEN(WL), .ARB_MODE(1), .TIMEOUT_CYCLES(16)
  ) dut_f (
    .clk(clk), .rst_n(rst_n),
    .p_rd(p_rd), .p_wr(p_wr),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdy(f_p_rdy), .p_rvalid(f_p_rvalid),
    .p_wvalid(f_p_wvalid), .p_error(f_p_error),
    .p_rdata(f_p_rdata),
    .m_rd(f_m_rd), .m_wr(f_m_wr),
    .m_addr(f_m_addr), .m_wdata(f_m_wdata),
    .m_rdy(f_m_rdy), .m_rvalid(f_m_rvalid),
    .m_wvalid(f_m_wvalid), .m_error(1'b0),
    .m_rdata(32'h0000_F1ED), .busy(f_busy)
  );

  // Fixed-priority instance: accept at once, complete next cycle.
  assign f_m_rdy = f_m_rd | (|f_m_wr);
  always @(posedge clk) begin
    f_m_rvalid <= f_m_rd & f_m_rdy;
    f_m_wvalid <= (|f_m_wr) & f_m_rdy;
  end

  always @(negedge clk) begin
    if (fx_on && (|f_p_rdy)) begin
      fx_cnt++;
      if (f_p_rdy != 4'b0001) fx_bad++;
    end
  end

  task automatic nx;
    @(negedge clk);
  endtask

  task automatic clr_inputs;
    p_rd     = '0;
    p_wr     = '0;
    p_addr   = '0;
    p_wdata  = '0;
    m_rdy    = 1'b0;
    m_rvalid = 1'b0;
    m_wvalid = 1'b0;
    m_error  = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic do_reset;
    clr_inputs();
    rst_n = 1'b0;
    repeat (3) nx();
    rst_n = 1'b1;
    nx();
  endtask

  task automatic wait_mrd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_rd || (|m_wr)) begin
        ok = 1'b1;
        break;
      end
      nx();
    end
  endtask

  // Drives one transaction; resp = {rvalid, wvalid, error}.
  task automatic run_txn(
    input  int          port,
    input  bit          wr,
    input  logic [3:0]  strb,
    input  logic [31:0] addr,
    input  logic [2:0]  resp,
    input  logic [31:0] rdata,
    output logic [3:0]  rdy_seen,
    output bit          ok
  );
    if (wr) p_wr[port*WL +: WL] = strb;
    else    p_rd[port] = 1'b1;
    p_addr[port*AW +: AW] = addr;
    rdy_seen = '0;
    nx();
    wait_mrd(ok);
    if (ok) begin
      m_rdy = 1'b1;
      #1 rdy_seen = p_rdy;
      nx();
      m_rdy = 1'b0;
    end
    p_rd[port] = 1'b0;
    p_wr[port*WL +: WL] = '0;
    if (ok) begin
      {m_rvalid, m_wvalid, m_error} = resp;
      m_rdata = rdata;
      nx();
      {m_rvalid, m_wvalid, m_error} = 3'b000;
      m_rdata = '0;
      #1;
    end
  endtask

  task automatic test_reset;
    clr_inputs();
    rst_n = 1'b0;
    nx();
    nx();
    checks++;
    if ({p_rdy, p_rvalid, p_wvalid, p_error, busy} !== '0)
      $display("FAIL rst_low_pulses got=%h want=0",
               {p_rdy, p_rvalid, p_wvalid, p_error, busy});
    else passed++;
    rst_n = 1'b1;
    nx();
    nx();
    checks++;
    if ({m_rd, m_wr, m_addr, m_wdata, p_rdata} !== '0)
      $display("FAIL rst_ctrl_outs got=%h want=0",
               {m_rd, m_wr, m_addr, m_wdata, p_rdata});
    else passed++;
    checks++;
    if (dut.state !== IDLE || dut.rr_ptr !== 2'd0)
      $display("FAIL rst_state st=%0d ptr=%0d want 0/0",
               dut.state, dut.rr_ptr);
    else passed++;
  endtask

  task automatic test_single_read;
    p_rd[0] = 1'b1;
    p_addr[0*AW +: AW] = 32'h0000_0100;
    nx();
    checks++;
    if (m_rd !== 1'b0 || busy !== 1'b1)
      $display("FAIL rd_lat1 m_rd=%b busy=%b want 0/1", m_rd, busy);
    else passed++;
    nx();
    checks++;
    if (m_rd !== 1'b1 || m_addr !== 32'h100 || m_wr !== 4'b0)
      $display("FAIL rd_issue m_rd=%b addr=%h wr=%b want 1/100/0",
               m_rd, m_addr, m_wr);
    else passed++;
    m_rdy = 1'b1;
    #1;
    checks++;
    if (p_rdy !== 4'b0001)
      $display("FAIL rd_rdy got=%b want=0001", p_rdy);
    else passed++;
    nx();
    m_rdy   = 1'b0;
    p_rd[0] = 1'b0;
    #1;
    checks++;
    if (p_rdy !== 4'b0 || m_rd !== 1'b0)
      $display("FAIL rd_drop p_rdy=%b m_rd=%b want 0/0", p_rdy, m_rd);
    else passed++;
    m_rvalid = 1'b1;
    m_rdata  = 32'hDEAD_BEEF;
    nx();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    #1;
    checks++;
    if (p_rvalid !== 4'b0001 || p_rdata !== 32'hDEAD_BEEF ||
        p_error !== 4'b0 || busy !== 1'b0)
      $display("FAIL rd_resp rv=%b data=%h err=%b busy=%b",
               p_rvalid, p_rdata, p_error, busy);
    else passed++;
    nx();
    checks++;
    if (p_rvalid !== 4'b0)
      $display("FAIL rd_pulse_len got=%b want=0000", p_rvalid);
    else passed++;
  endtask

  task automatic test_write_strobes;
    p_wr[2*WL +: WL]    = 4'b0011;
    p_wdata[2*DW +: DW] = 32'h1234_5678;
    p_addr[2*AW +: AW]  = 32'h0000_2000;
    nx();
    // requester drops while in ISSUE; transfer must still happen
    p_wr[2*WL +: WL]    = '0;
    p_wdata[2*DW +: DW] = '0;
    nx();
    checks++;
    if (m_wr !== 4'b0011 || m_wdata !== 32'h1234_5678 ||
        m_addr !== 32'h2000 || m_rd !== 1'b0)
      $display("FAIL wr_issue wr=%b data=%h addr=%h rd=%b",
               m_wr, m_wdata, m_addr, m_rd);
    else passed++;
    m_rdy = 1'b1;
    #1;
    checks++;
    if (p_rdy !== 4'b0100)
      $display("FAIL wr_rdy got=%b want=0100", p_rdy);
    else passed++;
    nx();
    m_rdy    = 1'b0;
    m_wvalid = 1'b1;
    nx();
    m_wvalid = 1'b0;
    #1;
    checks++;
    if (p_wvalid !== 4'b0100 || p_rvalid !== 4'b0 ||
        p_error !== 4'b0)
      $display("FAIL wr_resp wv=%b rv=%b err=%b want 0100/0/0",
               p_wvalid, p_rvalid, p_error);
    else passed++;
    checks++;
    if (dut.rr_ptr !== 2'd3)
      $display("FAIL wr_ptr got=%0d want=3", dut.rr_ptr);
    else passed++;
  endtask

  task automatic test_rr_fairness;
    bit ok;
    logic [3:0] exp;
    do_reset();
    fx_cnt = 0;
    fx_bad = 0;
    fx_on  = 1'b1;
    p_rd   = '1;
    for (int t = 0; t < 8; t++) begin
      exp = 4'b0001 << (t % 4);
      wait_mrd(ok);
      checks++;
      if (!ok) begin
        $display("FAIL rr_grant%0d no m_rd within bound", t);
        continue;
      end
      m_rdy = 1'b1;
      #1;
      if (p_rdy !== exp)
        $display("FAIL rr_grant%0d got=%b want=%b", t, p_rdy, exp);
      else passed++;
      nx();
      m_rdy    = 1'b0;
      m_rvalid = 1'b1;
      nx();
      m_rvalid = 1'b0;
    end
    p_rd  = '0;
    fx_on = 1'b0;
    checks++;
    if (fx_cnt < 8)
      $display("FAIL fixed_count got=%0d want>=8", fx_cnt);
    else passed++;
    checks++;
    if (fx_bad !== 0)
      $display("FAIL fixed_grant non-port0 grants=%0d want=0", fx_bad);
    else passed++;
    repeat (6) nx();
  endtask

  task automatic test_watchdog;
    bit ok;
    int bad;
    logic [3:0] rdy;
    p_rd[1] = 1'b1;
    p_addr[1*AW +: AW] = 32'h0000_0300;
    nx();
    nx();
    m_rdy = 1'b1;
    #1;
    checks++;
    if (m_rd !== 1'b1 || p_rdy !== 4'b0010)
      $display("FAIL wd_issue m_rd=%b p_rdy=%b want 1/0010",
               m_rd, p_rdy);
    else passed++;
    p_rd[1] = 1'b0;
    nx();
    m_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (p_error !== 4'b0 || busy !== 1'b1) bad++;
      nx();
    end
    checks++;
    if (bad != 0)
      $display("FAIL wd_early bad_cycles=%0d want=0", bad);
    else passed++;
    checks++;
    if (p_error !== 4'b0010 || busy !== 1'b0 || p_rvalid !== 4'b0)
      $display("FAIL wd_fire err=%b busy=%b rv=%b want 0010/0/0",
               p_error, busy, p_rvalid);
    else passed++;
    m_rvalid = 1'b1;
    m_rdata  = 32'hBAD0_BAD0;
    nx();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    #1;
    checks++;
    if (p_rvalid !== 4'b0 || p_error !== 4'b0 || busy !== 1'b0)
      $display("FAIL wd_late rv=%b err=%b busy=%b want 0/0/0",
               p_rvalid, p_error, busy);
    else passed++;
    run_txn(3, 1'b0, 4'b0, 32'h0000_0400, 3'b100,
            32'hCAFE_0003, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b1000 || p_rvalid !== 4'b1000 ||
        p_rdata !== 32'hCAFE_0003)
      $display("FAIL wd_next ok=%b rdy=%b rv=%b data=%h",
               ok, rdy, p_rvalid, p_rdata);
    else passed++;
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    p_rd[1] = 1'b1;
    p_addr[1*AW +: AW] = 32'h0000_0500;
    nx();
    wait_mrd(ok);
    m_rdy = 1'b1;
    nx();
    m_rdy   = 1'b0;
    p_rd[1] = 1'b0;
    checks++;
    if (!ok || busy !== 1'b1 || dut.state !== WAIT)
      $display("FAIL rstw_pre ok=%b busy=%b st=%0d want 1/1/WAIT",
               ok, busy, dut.state);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({p_rdy, p_rvalid, p_wvalid, p_error, m_rd, m_wr,
         m_addr, m_wdata, p_rdata, busy} !== '0)
      $display("FAIL rstw_outs got=%h want=0",
               {p_rdy, p_rvalid, p_wvalid, p_error, m_rd, m_wr,
                m_addr, m_wdata, p_rdata, busy});
    else passed++;
    checks++;
    if (dut.state !== IDLE || dut.rr_ptr !== 2'd0)
      $display("FAIL rstw_state st=%0d ptr=%0d want 0/0",
               dut.state, dut.rr_ptr);
    else passed++;
    nx();
    rst_n = 1'b1;
    nx();
  endtask

  task automatic test_ctrl_error;
    bit ok;
    logic [3:0] rdy;
    run_txn(2, 1'b0, 4'b0, 32'h0000_0600, 3'b001,
            32'h1111_2222, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0100 || p_error !== 4'b0100 ||
        p_rvalid !== 4'b0 || p_wvalid !== 4'b0)
      $display("FAIL err_rd ok=%b rdy=%b err=%b rv=%b wv=%b",
               ok, rdy, p_error, p_rvalid, p_wvalid);
    else passed++;
    checks++;
    if (dut.rr_ptr !== 2'd3)
      $display("FAIL err_ptr got=%0d want=3", dut.rr_ptr);
    else passed++;
    nx();
    run_txn(1, 1'b0, 4'b0, 32'h0000_0700, 3'b010,
            32'h0, rdy, ok);
    checks++;
    if (!ok || p_error !== 4'b0010 || p_wvalid !== 4'b0 ||
        p_rvalid !== 4'b0)
      $display("FAIL err_mismatch ok=%b err=%b wv=%b rv=%b",
               ok, p_error, p_wvalid, p_rvalid);
    else passed++;
    nx();
    run_txn(0, 1'b1, 4'b1111, 32'h0000_0800, 3'b011,
            32'h0, rdy, ok);
    checks++;
    if (!ok || rdy !== 4'b0001 || p_error !== 4'b0001 ||
        p_wvalid !== 4'b0)
      $display("FAIL err_multi ok=%b rdy=%b err=%b wv=%b",
               ok, rdy, p_error, p_wvalid);
    else passed++;
    nx();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    test_reset();
    test_single_read();
    test_write_strobes();
    test_rr_fairness();
    test_watchdog();
    test_reset_mid_wait();
    test_ctrl_error();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish, passed=%0d",
             passed);
    $fatal(1);
  end

endmodule
